moore_stim_seq: RTL and testbench

Stimulus sequencer that drives the two-state Moore switch FSM. It accepts a command of NSYM 2-bit switch symbols and presents each symbol on the FSM's switch input, then issues a one-cycle control strobe. After each strobe it captures the FSM's registered output and compares it against an internal model of the FSM. It sits between a host or test controller and the FSM and returns the captured output bits plus an error flag through a valid/ready response channel.

---
 rtl/moore_stim_seq.sv | 164 ++++++++++++++++
 tb/tb_moore_stim_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/moore_stim_seq.sv
// Purpose: stimulus sequencer for the two-state Moore switch FSM; applies symbols, strobes, captures and checks out.
// Latency: accept to rsp_valid = 4 + (NSYM-1)*(3+GAP) cycles; per-symbol period 3+GAP.
// Backpressure: cmd_ready only in IDLE (source holds commands); DONE holds the response until rsp_ready.
module moore_stim_seq #(
  parameter int NSYM = 4,
  parameter int GAP  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2*NSYM-1:0] cmd_syms,
  output logic [1:0]        sw_out,
  output logic              ctrl_out,
  input  logic              fsm_out,
  input  logic              fsm_state,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [NSYM-1:0]   rsp_bits,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IW = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSYM - 1);
  // WAIT counts down from GAP-1 to 0, giving exactly GAP idle cycles.
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_CAPTURE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2*NSYM-1:0] syms_q;
  logic [IW-1:0]     idx;
  logic [GW-1:0]     gap_cnt;
  logic              model_state;
  logic [1:0]        cur_sym;
  logic              exp_out;
  logic              model_nxt;
  logic              accept;
  logic              last_sym;

  assign accept   = cmd_valid && (state == S_IDLE);
  assign last_sym = (idx == LAST_IDX);
  assign cur_sym  = syms_q[{idx, 1'b0} +: 2];

  // Reference model of the FSM: output reflects the state before the strobe.
  assign exp_out   = ~model_state;
  assign model_nxt = model_state ? ((cur_sym == 2'd0) || (cur_sym == 2'd2))
                                 : (cur_sym != 2'd0);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    ctrl_out  = 1'b0;
    busy      = 1'b1;
    sw_out    = 2'b00;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        sw_out    = cur_sym;
        state_nxt = S_STROBE;
      end
      S_STROBE: begin
        sw_out    = cur_sym;
        ctrl_out  = 1'b1;
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (last_sym) begin
          state_nxt = S_DONE;
        end else if (GAP > 0) begin
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_SETUP;
        end
      end
      S_WAIT: begin
        if (gap_cnt == '0) begin
          state_nxt = S_SETUP;
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Command latch, symbol index, gap counter, model and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syms_q      <= '0;
      idx         <= '0;
      gap_cnt     <= '0;
      model_state <= 1'b0;
      rsp_bits    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            syms_q   <= cmd_syms;
            idx      <= '0;
            rsp_bits <= '0;
            rsp_err  <= 1'b0;
          end
        end
        S_SETUP: begin
          if (idx == '0) begin
            model_state <= fsm_state;
          end
        end
        S_CAPTURE: begin
          rsp_bits[idx] <= fsm_out;
          rsp_err       <= rsp_err | (fsm_out != exp_out);
          model_state   <= model_nxt;
          idx           <= idx + 1'b1;
          if (!last_sym) begin
            gap_cnt <= GAP_LOAD;
          end
        end
        S_WAIT: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moore_stim_seq.sv
// Bench for moore_stim_seq: GAP=2 and GAP=0 instances, each driving its own behavioural switch FSM.
// Directed commands with hand-computed strobe cycles, response bits and error flags.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_moore_stim_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       cmd_valid;
  logic [7:0] cmd_syms;
  logic       rsp_ready;
  logic       sel;        // 0: GAP=2 instance, 1: GAP=0 instance
  logic       force_one;  // forces the GAP=2 instance's fsm_out high
  logic       fsm_load;
  logic       seed_a;
  logic       seed_b;

  // GAP=2 instance signals
  logic       rdy_a, ctrl_a, vld_a, err_a, busy_a;
  logic [1:0] sw_a;
  logic [3:0] bits_a;
  logic       fs_a = 1'b0;
  logic       fq_a = 1'b0;

  // GAP=0 instance signals
  logic       rdy_b, ctrl_b, vld_b, err_b, busy_b;
  logic [1:0] sw_b;
  logic [3:0] bits_b;
  logic       fs_b = 1'b0;
  logic       fq_b = 1'b0;

  moore_stim_seq #(.NSYM(4), .GAP(2)) u_gap2 (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid & ~sel),
    .cmd_ready (rdy_a),
    .cmd_syms  (cmd_syms),
    .sw_out    (sw_a),
    .ctrl_out  (ctrl_a),
    .fsm_out   (fq_a | force_one),
    .fsm_state (fs_a),
    .rsp_valid (vld_a),
    .rsp_ready (rsp_ready & ~sel),
    .rsp_bits  (bits_a),
    .rsp_err   (err_a),
    .busy      (busy_a)
  );

  moore_stim_seq #(.NSYM(4), .GAP(0)) u_gap0 (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid & sel),
    .cmd_ready (rdy_b),
    .cmd_syms  (cmd_syms),
    .sw_out    (sw_b),
    .ctrl_out  (ctrl_b),
    .fsm_out   (fq_b),
    .fsm_state (fs_b),
    .rsp_valid (vld_b),
    .rsp_ready (rsp_ready & sel),
    .rsp_bits  (bits_b),
    .rsp_err   (err_b),
    .busy      (busy_b)
  );

  // Switch FSM behaviour: on a strobe, out takes the pre-strobe Moore output and the state advances.
  function automatic logic fsm_next(input logic st, input logic [1:0] s);
    return st ? ((s == 2'd0) || (s == 2'd2)) : (s != 2'd0);
  endfunction

  // Behavioural FSM attached to the GAP=2 instance.
  always @(posedge clk) begin
    if (fsm_load) begin
      fs_a <= seed_a;
      fq_a <= 1'b0;
    end else if (ctrl_a) begin
      fq_a <= ~fs_a;
      fs_a <= fsm_next(fs_a, sw_a);
    end
  end

  // Behavioural FSM attached to the GAP=0 instance.
  always @(posedge clk) begin
    if (fsm_load) begin
      fs_b <= seed_b;
      fq_b <= 1'b0;
    end else if (ctrl_b) begin
      fq_b <= ~fs_b;
      fs_b <= fsm_next(fs_b, sw_b);
    end
  end

  logic       o_ready, o_ctrl, o_vld, o_err, o_busy;
  logic [1:0] o_sw;
  logic [3:0] o_bits;
  assign o_ready = sel ? rdy_b  : rdy_a;
  assign o_ctrl  = sel ? ctrl_b : ctrl_a;
  assign o_vld   = sel ? vld_b  : vld_a;
  assign o_err   = sel ? err_b  : err_a;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_sw    = sel ? sw_b   : sw_a;
  assign o_bits  = sel ? bits_b : bits_a;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] strobe_mask;
  int          first_valid;
  logic [7:0]  sw_seen;
  int          nstrobe;

  // Presents a command in the current cycle (cycle 0) and observes cycles 1..ncyc.
  task automatic run_cmd(input logic [7:0] syms, input int ncyc);
    strobe_mask = '0;
    first_valid = -1;
    sw_seen     = '0;
    nstrobe     = 0;
    cmd_syms    = syms;
    cmd_valid   = 1'b1;
    check("accept_ready", o_ready, 1);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      if (o_ctrl) begin
        strobe_mask[c] = 1'b1;
        if (nstrobe < 4) sw_seen[2*nstrobe +: 2] = o_sw;
        nstrobe++;
      end
      if (o_vld && first_valid < 0) first_valid = c;
    end
  endtask

  task automatic seed_fsms(input logic a, input logic b);
    seed_a   = a;
    seed_b   = b;
    fsm_load = 1'b1;
    @(negedge clk);
    fsm_load = 1'b0;
  endtask

  task automatic complete_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_after_rsp", o_ready, 1);
  endtask

  int bad;

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_syms  = 8'h00;
    rsp_ready = 1'b0;
    sel       = 1'b0;
    force_one = 1'b0;
    fsm_load  = 1'b0;
    seed_a    = 1'b0;
    seed_b    = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", o_ready, 1);
    check("rst_ctrl", o_ctrl, 0);
    check("rst_sw", o_sw, 0);
    check("rst_rsp_valid", o_vld, 0);
    check("rst_rsp_bits", o_bits, 0);
    check("rst_rsp_err", o_err, 0);
    check("rst_busy", o_busy, 0);
    reset = 1'b1;
    seed_fsms(1'b0, 1'b1);

    // GAP=2, FSM state 0, symbols 3,1,2,0; response held 10 cycles
    run_cmd(8'h27, 19);
    check("t1_strobe_cycles", strobe_mask, 32'h0002_1084);
    check("t1_sw_values", sw_seen, 8'h27);
    check("t1_valid_cycle", first_valid, 19);
    check("t1_rsp_bits", o_bits, 4'b0101);
    check("t1_rsp_err", o_err, 0);
    check("t1_busy_done", o_busy, 1);
    cmd_valid = 1'b1;  // queued next command, held while busy
    cmd_syms  = 8'h27;
    force_one = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_vld !== 1'b1 || o_bits !== 4'b0101 || o_err !== 1'b0 || o_ready !== 1'b0) bad++;
    end
    check("hold_stable", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_after_hold", o_ready, 1);
    check("valid_drop_after_hold", o_vld, 0);

    // Queued command accepted in that IDLE cycle; fsm_out stuck at 1
    run_cmd(8'h27, 19);
    check("forced_valid_cycle", first_valid, 19);
    check("forced_rsp_bits", o_bits, 4'b1111);
    check("forced_rsp_err", o_err, 1);
    complete_rsp();
    force_one = 1'b0;

    // Reset during STROBE
    seed_fsms(1'b0, 1'b1);
    run_cmd(8'h27, 2);
    check("pre_rst_strobe", o_ctrl, 1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_ctrl", o_ctrl, 0);
    check("async_rst_ready", o_ready, 1);
    check("async_rst_valid", o_vld, 0);
    check("async_rst_busy", o_busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (o_ctrl !== 1'b0 || o_vld !== 1'b0) bad++;
    end
    check("no_activity_after_rst", bad, 0);
    // State 0 with symbol 0 stays in state 0, so every capture reads 1.
    run_cmd(8'h00, 19);
    check("post_rst_valid_cycle", first_valid, 19);
    check("post_rst_rsp_bits", o_bits, 4'b1111);
    check("post_rst_rsp_err", o_err, 0);
    complete_rsp();

    // GAP=0, FSM state 1, all symbols 3
    sel = 1'b1;
    seed_fsms(1'b0, 1'b1);
    run_cmd(8'hFF, 13);
    check("g0_strobe_cycles", strobe_mask, 32'h0000_0924);
    check("g0_sw_values", sw_seen, 8'hFF);
    check("g0_valid_cycle", first_valid, 13);
    check("g0_rsp_bits", o_bits, 4'b1010);
    check("g0_rsp_err", o_err, 0);
    complete_rsp();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
